approx_err_accum: RTL and testbench

APPROX_ERR_ACCUM -- requirements
Module: approx_err_accum

---
 rtl/approx_err_accum.sv | 199 +++++++++++++++++++
 tb/tb_approx_err_accum.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_err_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | approx_err_accum : error-distance statistics for a 16x16 approx multiplier  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module approx_err_accum #(
   parameter int ACC_W = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   input  logic [31:0]      in_y,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] sum_ed,
   output logic [31:0]      max_ed,
   output logic [15:0]      err_count,
   output logic             sum_sat
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      n_q, n_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             zpend_q, zpend_d;
   logic             s1_v_q, s1_v_d;
   logic [15:0]      s1_a_q, s1_a_d;
   logic [15:0]      s1_b_q, s1_b_d;
   logic [31:0]      s1_y_q, s1_y_d;
   logic             s2_v_q, s2_v_d;
   logic [31:0]      s2_ed_q, s2_ed_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [31:0]      max_q, max_d;
   logic [15:0]      errc_q, errc_d;
   logic             sat_q, sat_d;

   logic             accept;
   logic [31:0]      prod;
   logic [31:0]      ed;
   logic [ACC_W:0]   sum_ext;

   assign accept  = (state_q == S_RUN) && ready_q && in_valid;
   assign prod    = 32'(s1_a_q) * 32'(s1_b_q);
   // Subtract in the direction that cannot wrap.
   assign ed      = (prod >= s1_y_q) ? (prod - s1_y_q) : (s1_y_q - prod);
   assign sum_ext = {1'b0, sum_q} + {{(ACC_W-31){1'b0}}, s2_ed_q};

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      zpend_d = zpend_q;
      s1_v_d  = accept;
      s1_a_d  = s1_a_q;
      s1_b_d  = s1_b_q;
      s1_y_d  = s1_y_q;
      s2_v_d  = s1_v_q;
      s2_ed_d = s2_ed_q;
      sum_d   = sum_q;
      max_d   = max_q;
      errc_d  = errc_q;
      sat_d   = sat_q;

      if (accept) begin
         s1_a_d = in_a;
         s1_b_d = in_b;
         s1_y_d = in_y;
      end
      if (s1_v_q) begin
         s2_ed_d = ed;
      end
      if (s2_v_q) begin
         if (sum_ext[ACC_W]) begin
            sum_d = '1;
            sat_d = 1'b1;
         end else begin
            sum_d = sum_ext[ACC_W-1:0];
         end
         if (s2_ed_q > max_q) begin
            max_d = s2_ed_q;
         end
         if (s2_ed_q != 32'd0) begin
            errc_d = errc_q + 16'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (zpend_q) begin
               // Empty run: the done pulse follows the single busy cycle.
               zpend_d = 1'b0;
               done_d  = 1'b1;
            end else if (start) begin
               busy_d = 1'b1;
               n_d    = num_samples;
               cnt_d  = 16'd0;
               sum_d  = '0;
               max_d  = 32'd0;
               errc_d = 16'd0;
               sat_d  = 1'b0;
               if (num_samples == 16'd0) begin
                  zpend_d = 1'b1;
               end else begin
                  state_d = S_RUN;
                  ready_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (accept) begin
               cnt_d = cnt_q + 16'd1;
               if ((cnt_q + 16'd1) == n_q) begin
                  state_d = S_DRAIN;
                  ready_d = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            // Stage 1 is empty here, so a lone stage-2 sample is the last one.
            if (s2_v_q && !s1_v_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= 16'd0;
         cnt_q   <= 16'd0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         zpend_q <= 1'b0;
         s1_v_q  <= 1'b0;
         s1_a_q  <= 16'd0;
         s1_b_q  <= 16'd0;
         s1_y_q  <= 32'd0;
         s2_v_q  <= 1'b0;
         s2_ed_q <= 32'd0;
         sum_q   <= '0;
         max_q   <= 32'd0;
         errc_q  <= 16'd0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         zpend_q <= zpend_d;
         s1_v_q  <= s1_v_d;
         s1_a_q  <= s1_a_d;
         s1_b_q  <= s1_b_d;
         s1_y_q  <= s1_y_d;
         s2_v_q  <= s2_v_d;
         s2_ed_q <= s2_ed_d;
         sum_q   <= sum_d;
         max_q   <= max_d;
         errc_q  <= errc_d;
         sat_q   <= sat_d;
      end
   end

   assign in_ready  = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sum_ed    = sum_q;
   assign max_ed    = max_q;
   assign err_count = errc_q;
   assign sum_sat   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_err_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_approx_err_accum : scoreboard bench, 48-bit and 32-bit accumulators      |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_approx_err_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num_samples = 16'd0;
   logic        in_valid = 1'b0;
   logic [15:0] in_a = 16'd0;
   logic [15:0] in_b = 16'd0;
   logic [31:0] in_y = 32'd0;

   logic        rdy48, busy48, done48, sat48;
   logic [47:0] sum48;
   logic [31:0] max48;
   logic [15:0] cnt48;
   logic        rdy32, busy32, done32, sat32;
   logic [31:0] sum32;
   logic [31:0] max32;
   logic [15:0] cnt32;

   approx_err_accum u_dut48 (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(rdy48), .in_a(in_a), .in_b(in_b), .in_y(in_y),
      .busy(busy48), .done(done48), .sum_ed(sum48), .max_ed(max48),
      .err_count(cnt48), .sum_sat(sat48)
   );

   approx_err_accum #(.ACC_W(32)) u_dut32 (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(rdy32), .in_a(in_a), .in_b(in_b), .in_y(in_y),
      .busy(busy32), .done(done32), .sum_ed(sum32), .max_ed(max32),
      .err_count(cnt32), .sum_sat(sat32)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] s48;
      logic [63:0] s32;
      logic        sat48;
      logic        sat32;
      logic [31:0] mx;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] m_s48, m_s32;
   logic        m_sat48, m_sat32;
   logic [31:0] m_max;
   logic [15:0] m_cnt;
   int          errors = 0;
   int          checks = 0;
   int          acc_cyc = 0;
   int          first_cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_clear();
      m_s48 = 64'd0; m_s32 = 64'd0; m_sat48 = 1'b0; m_sat32 = 1'b0;
      m_max = 32'd0; m_cnt = 16'd0;
   endtask

   task automatic model_add(input logic [15:0] a, input logic [15:0] b, input logic [31:0] y);
      logic [31:0] e;
      logic [31:0] d;
      e = {16'd0, a} * {16'd0, b};
      d = (e >= y) ? e - y : y - e;
      m_s48 = m_s48 + {32'd0, d};
      if (m_s48 > 64'hFFFF_FFFF_FFFF) begin m_s48 = 64'hFFFF_FFFF_FFFF; m_sat48 = 1'b1; end
      m_s32 = m_s32 + {32'd0, d};
      if (m_s32 > 64'hFFFF_FFFF) begin m_s32 = 64'hFFFF_FFFF; m_sat32 = 1'b1; end
      if (d > m_max) m_max = d;
      if (d != 32'd0) m_cnt = m_cnt + 16'd1;
   endtask

   task automatic push_exp();
      exp_t e;
      e.s48 = m_s48; e.s32 = m_s32; e.sat48 = m_sat48; e.sat32 = m_sat32;
      e.mx = m_max; e.cnt = m_cnt;
      sb.push_back(e);
   endtask

   // Called at a falling edge; start is sampled on the following rising edge.
   task automatic do_start(input logic [15:0] n);
      start = 1'b1;
      num_samples = n;
      @(negedge clk);
      start = 1'b0;
      model_clear();
   endtask

   // Holds the sample until the DUT accepts it; returns at the falling edge after acceptance.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] y);
      bit got;
      got = 1'b0;
      in_a = a; in_b = b; in_y = y; in_valid = 1'b1;
      for (int t = 0; t < 40 && !got; t++) begin
         got = rdy48;
         @(negedge clk);
      end
      chk("accept", {63'd0, got}, 64'd1);
      if (got) begin
         model_add(a, b, y);
         acc_cyc = cyc;
      end
   endtask

   task automatic wait_done(input string tag, input int ref_cyc, input int lat);
      exp_t e;
      logic [63:0] held;
      for (int t = 0; t < 40 && !done48; t++) @(negedge clk);
      chk({tag, "_done48"}, {63'd0, done48}, 64'd1);
      chk({tag, "_done32"}, {63'd0, done32}, 64'd1);
      chk({tag, "_latency"}, 64'(cyc - ref_cyc), 64'(lat));
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_sum48"}, {16'd0, sum48}, e.s48);
         chk({tag, "_sum32"}, {32'd0, sum32}, e.s32);
         chk({tag, "_sat48"}, {63'd0, sat48}, {63'd0, e.sat48});
         chk({tag, "_sat32"}, {63'd0, sat32}, {63'd0, e.sat32});
         chk({tag, "_max48"}, {32'd0, max48}, {32'd0, e.mx});
         chk({tag, "_max32"}, {32'd0, max32}, {32'd0, e.mx});
         chk({tag, "_cnt48"}, {48'd0, cnt48}, {48'd0, e.cnt});
         chk({tag, "_cnt32"}, {48'd0, cnt32}, {48'd0, e.cnt});
         held = {16'd0, sum48};
         @(negedge clk);
         chk({tag, "_pulse"}, {62'd0, done48, done32}, 64'd0);
         chk({tag, "_idle_busy"}, {62'd0, busy48, busy32}, 64'd0);
         chk({tag, "_hold_sum"}, {16'd0, sum48}, held);
         chk({tag, "_hold_max"}, {32'd0, max48}, {32'd0, e.mx});
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl48"}, {60'd0, rdy48, busy48, done48, sat48}, 64'd0);
      chk({tag, "_ctl32"}, {60'd0, rdy32, busy32, done32, sat32}, 64'd0);
      chk({tag, "_sum48"}, {16'd0, sum48}, 64'd0);
      chk({tag, "_sum32"}, {32'd0, sum32}, 64'd0);
      chk({tag, "_max_cnt48"}, {16'd0, max48, cnt48}, 64'd0);
      chk({tag, "_max_cnt32"}, {16'd0, max32, cnt32}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit done_seen;
      int ref_cyc;
      model_clear();
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single sample: 3*3=9 vs 7
      do_start(16'd1);
      chk("t1_busy", {63'd0, busy48}, 64'd1);
      send(16'd3, 16'd3, 32'd7);
      in_valid = 1'b0;
      push_exp();
      wait_done("t1", acc_cyc, 2);

      // Four exact products, back to back
      do_start(16'd4);
      send(16'h00FF, 16'h0101, 32'h0000FFFF);
      first_cyc = acc_cyc;
      for (int i = 0; i < 3; i++) send(16'h00FF, 16'h0101, 32'h0000FFFF);
      in_valid = 1'b0;
      chk("t2_b2b_span", 64'(acc_cyc - first_cyc), 64'd3);
      push_exp();
      wait_done("t2", first_cyc, 5);

      // Extreme operand, 3-cycle valid gap, then a small error
      do_start(16'd2);
      send(16'hFFFF, 16'hFFFF, 32'd0);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      send(16'd2, 16'd2, 32'd5);
      in_valid = 1'b0;
      push_exp();
      wait_done("t3", acc_cyc, 2);

      // Saturation of the 32-bit accumulator
      do_start(16'd2);
      send(16'hFFFF, 16'hFFFF, 32'd0);
      send(16'hFFFF, 16'hFFFF, 32'd0);
      in_valid = 1'b0;
      push_exp();
      wait_done("t4", acc_cyc, 2);

      // Empty run
      do_start(16'd0);
      ref_cyc = cyc;
      chk("t5_busy", {62'd0, busy48, busy32}, 64'd3);
      push_exp();
      wait_done("t5", ref_cyc, 1);

      // start pulsed during RUN is ignored
      do_start(16'd3);
      send(16'd10, 16'd10, 32'd90);
      in_valid = 1'b0;
      start = 1'b1;
      num_samples = 16'd1;
      @(negedge clk);
      start = 1'b0;
      chk("t6_still_ready", {62'd0, rdy48, rdy32}, 64'd3);
      send(16'd5, 16'd6, 32'd40);
      send(16'd7, 16'd7, 32'd49);
      in_valid = 1'b0;
      push_exp();
      wait_done("t6", acc_cyc, 2);

      // in_valid held high past the sample count
      do_start(16'd2);
      send(16'd1, 16'd1, 32'd0);
      send(16'd2, 16'd3, 32'd0);
      in_a = 16'hFFFF; in_b = 16'hFFFF; in_y = 32'd0;
      chk("t7_ready_low", {62'd0, rdy48, rdy32}, 64'd0);
      push_exp();
      wait_done("t7", acc_cyc, 2);
      in_valid = 1'b0;

      // Reset mid-run, with a handshake pending on the reset edge
      do_start(16'd5);
      send(16'd9, 16'd9, 32'd1);
      send(16'd8, 16'd8, 32'd2);
      in_a = 16'd4; in_b = 16'd4; in_y = 32'd0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      check_zero("t8_rst");
      done_seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         done_seen = done_seen | done48 | done32;
      end
      chk("t8_no_done", {63'd0, done_seen}, 64'd0);
      do_start(16'd1);
      send(16'd100, 16'd7, 32'd650);
      in_valid = 1'b0;
      push_exp();
      wait_done("t8", acc_cyc, 2);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
